// File: rtl/div8_seq_if.sv
// div8_seq_if: request/result bundle for the iterative divider.
//   master modport: the controller that issues divisions (drives start and
//                   operands, observes status and results).
//   slave modport : the divider itself.
// Signals:
//   start       request pulse, sampled only while the divider is idle
//   signed_op   1 = two's-complement operands, 0 = unsigned
//   dividend    numerator, sampled with start
//   divisor     denominator, sampled with start
//   busy        high from the cycle after acceptance through the done cycle
//   done        one-cycle completion pulse
//   quotient    result quotient, held until the next accepted start
//   remainder   result remainder, held the same way
//   div_by_zero error flag of the last operation
//   overflow    signed overflow flag (most-negative / -1)
interface div8_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start,
    output signed_op,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero,
    input  overflow
  );

  modport slave (
    input  start,
    input  signed_op,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero,
    output overflow
  );
endinterface

// File: rtl/div8_seq.sv
// div8_seq: iterative restoring divider, one quotient bit per clock.
// Supports unsigned and signed (two's-complement, truncating) division.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  div8_seq_if.slave: start/operands in, busy/done/results out
// Timing (WIDTH=8): start accepted at edge 0, WIDTH CALC iterations at
// edges 1..WIDTH, results loaded at edge WIDTH+1 and done high in the
// following cycle. A zero divisor loads its results at the acceptance edge
// and raises done one cycle later.
module div8_seq #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  div8_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    LAST_IT  = CW'(WIDTH - 1);

  // Control state
  logic [1:0]       state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  // Datapath: partial remainder (one guard bit), quotient/dividend shifter,
  // divisor magnitude
  logic [WIDTH:0]   r_q,        r_d;
  logic [WIDTH-1:0] qs_q,       qs_d;
  logic [WIDTH-1:0] dv_q,       dv_d;
  // Sign and special-case bookkeeping for the operation in flight
  logic             q_neg_q,    q_neg_d;
  logic             r_neg_q,    r_neg_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             zero_q,     zero_d;
  // Architectural result registers
  logic [WIDTH-1:0] quo_q,      quo_d;
  logic [WIDTH-1:0] rem_q,      rem_d;
  logic             dz_q,       dz_d;
  logic             ovf_q,      ovf_d;

  // Operand signs and magnitudes. Negating the most-negative value yields
  // the same bit pattern, which read as unsigned is the correct magnitude.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_neg = bus.signed_op & bus.dividend[WIDTH-1];
  assign b_neg = bus.signed_op & bus.divisor[WIDTH-1];
  assign a_mag = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
  assign b_mag = b_neg ? (~bus.divisor  + 1'b1) : bus.divisor;

  // One restoring step: bring in the next dividend bit, try subtracting.
  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] trial;

  assign r_shift = {r_q[WIDTH-1:0], qs_q[WIDTH-1]};
  assign trial   = r_shift - {1'b0, dv_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    qs_d       = qs_q;
    dv_d       = dv_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    ovf_pend_d = ovf_pend_q;
    zero_d     = zero_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dz_d       = dz_q;
    ovf_d      = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            // Results are fixed immediately; the pass through FIX only
            // supplies the extra cycle before done and leaves them alone.
            quo_d   = ALL_ONES;
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            zero_d  = 1'b1;
            state_d = S_FIX;
          end else begin
            r_d        = '0;
            qs_d       = a_mag;
            dv_d       = b_mag;
            q_neg_d    = a_neg ^ b_neg;
            r_neg_d    = a_neg;
            ovf_pend_d = bus.signed_op && (bus.dividend == MIN_NEG) &&
                         (bus.divisor == ALL_ONES);
            zero_d     = 1'b0;
            cnt_d      = '0;
            state_d    = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (!trial[WIDTH]) begin
          r_d  = trial;
          qs_d = {qs_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d  = r_shift;
          qs_d = {qs_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IT) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (!zero_q) begin
          quo_d = q_neg_q ? (~qs_q + 1'b1) : qs_q;
          rem_d = r_neg_q ? (~r_q[WIDTH-1:0] + 1'b1) : r_q[WIDTH-1:0];
          // Overflow needs no datapath fix-up: 128/1 with q_neg=0 already
          // wraps to the most-negative pattern with a zero remainder.
          ovf_d = ovf_pend_q;
          dz_d  = 1'b0;
        end
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      r_q        <= '0;
      qs_q       <= '0;
      dv_q       <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
      zero_q     <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      qs_q       <= qs_d;
      dv_q       <= dv_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      ovf_pend_q <= ovf_pend_d;
      zero_q     <= zero_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
    end
  end

  // Status is a pure decode of the state register, so reset clears it
  // at once and done can never last more than the single DONE cycle.
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ovf_q;

endmodule
